// File: rtl/header_remover_if.sv
// Avalon-ST stream bundle: data with valid/ready handshake and sop/eop/empty framing.
// The master drives the payload and framing; the slave drives ready.
interface avalon_st_if #(
    parameter int DATA_WIDTH = 128
);
    localparam int EMPTY_WIDTH = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1;

    logic [DATA_WIDTH-1:0]  data;
    logic                   valid;
    logic                   ready;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;

    modport master (output data, valid, sop, eop, empty, input ready);
    modport slave  (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/header_remover.sv
// Strips a fixed-size header from each Avalon-ST packet, captures it into header_data,
// and forwards the payload with zero latency and regenerated sop/eop/empty.
module header_remover #(
    parameter int DATA_WIDTH  = 128,
    parameter int HEADER_SIZE = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    avalon_st_if.slave             data_in,
    avalon_st_if.master            data_out,
    output logic [HEADER_SIZE-1:0] header_data,
    output logic                   header_valid,
    output logic                   header_error
);
    localparam int HWC = HEADER_SIZE / DATA_WIDTH;
    localparam int CW  = $clog2(HWC) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(HWC - 1);

    typedef enum logic [1:0] {IDLE_ST, HEADER_ST, DATA_ST} state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_hdr_cntr;
    logic [HEADER_SIZE-1:0] r_header_data;
    logic                   r_header_valid;
    logic                   r_header_error;
    logic                   r_first_flag;

    logic          w_in_data_st;
    logic          w_beat;
    logic          w_hdr_wr;
    logic [CW-1:0] w_wr_idx;

    assign w_in_data_st = (r_state == DATA_ST);
    assign w_beat       = data_in.valid & data_in.ready;
    assign w_hdr_wr     = w_beat & (((r_state == IDLE_ST) & data_in.sop) | (r_state == HEADER_ST));
    assign w_wr_idx     = (r_state == IDLE_ST) ? '0 : r_hdr_cntr;

    // Header is absorbed unconditionally; only the payload phase honours downstream ready.
    assign data_in.ready  = w_in_data_st ? data_out.ready : 1'b1;
    assign data_out.valid = w_in_data_st & data_in.valid;
    assign data_out.data  = data_in.data;
    assign data_out.sop   = r_first_flag;
    assign data_out.eop   = data_in.eop;
    assign data_out.empty = data_in.eop ? data_in.empty : '0;

    assign header_data  = r_header_data;
    assign header_valid = r_header_valid;
    assign header_error = r_header_error;

    // Word 0 lands in the MSBs of the header register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_header_data <= '0;
        end else if (w_hdr_wr) begin
            for (int i = 0; i < HWC; i++) begin
                if (w_wr_idx == CW'(i))
                    r_header_data[HEADER_SIZE-1-DATA_WIDTH*i -: DATA_WIDTH] <= data_in.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE_ST;
            r_hdr_cntr     <= '0;
            r_header_valid <= 1'b0;
            r_header_error <= 1'b0;
            r_first_flag   <= 1'b1;
        end else begin
            r_header_valid <= 1'b0;
            r_header_error <= 1'b0;
            case (r_state)
                IDLE_ST: begin
                    if (w_beat && data_in.sop) begin
                        if (data_in.eop) begin
                            r_header_error <= 1'b1;
                        end else if (HWC == 1) begin
                            r_header_valid <= 1'b1;
                            r_first_flag   <= 1'b1;
                            r_state        <= DATA_ST;
                        end else begin
                            r_hdr_cntr <= CW'(1);
                            r_state    <= HEADER_ST;
                        end
                    end
                end
                HEADER_ST: begin
                    if (w_beat) begin
                        if (r_hdr_cntr == LAST_IDX) begin
                            // A packet ending exactly on the last header word carries no payload.
                            r_header_valid <= 1'b1;
                            r_hdr_cntr     <= '0;
                            r_first_flag   <= 1'b1;
                            r_state        <= data_in.eop ? IDLE_ST : DATA_ST;
                        end else if (data_in.eop) begin
                            r_header_error <= 1'b1;
                            r_hdr_cntr     <= '0;
                            r_state        <= IDLE_ST;
                        end else begin
                            r_hdr_cntr <= r_hdr_cntr + 1'b1;
                        end
                    end
                end
                DATA_ST: begin
                    if (w_beat) begin
                        r_first_flag <= 1'b0;
                        if (data_in.eop) begin
                            r_first_flag <= 1'b1;
                            r_state      <= IDLE_ST;
                        end
                    end
                end
                default: r_state <= IDLE_ST;
            endcase
        end
    end
endmodule

// File: tb/tb_header_remover.sv
// Bench for header_remover: three instances (HWC = 2, 3, 1) share one stimulus bus selected by sel,
// exercised with directed per-cycle vector tables and randomized packets against a packet-level model.
module tb_header_remover;
    localparam int DW = 128;

    typedef struct {
        logic          v, sop, eop;
        logic [DW-1:0] d;
        logic [3:0]    e;
        logic          rdy;
        logic          xInReady, xOutValid, xSop, xEop;
        logic [DW-1:0] xData;
        logic [3:0]    xEmpty;
        logic          xHv, xHe;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          sop, eop;
        logic [3:0]    e;
    } beat_t;

    typedef struct {
        logic       isErr;
        logic [383:0] hdr;
    } hev_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]    sel;
    logic          inValid, inSop, inEop, outReady;
    logic [DW-1:0] inData;
    logic [3:0]    inEmpty;

    avalon_st_if #(.DATA_WIDTH(DW)) in256 (), out256 (), in384 (), out384 (), in128 (), out128 ();

    logic [255:0] hdr256;
    logic [383:0] hdr384;
    logic [127:0] hdr128;
    logic hv256, he256, hv384, he384, hv128, he128;

    assign in256.valid = inValid && (sel == 2'd0);
    assign in256.data  = inData;
    assign in256.sop   = inSop;
    assign in256.eop   = inEop;
    assign in256.empty = inEmpty;
    assign in384.valid = inValid && (sel == 2'd1);
    assign in384.data  = inData;
    assign in384.sop   = inSop;
    assign in384.eop   = inEop;
    assign in384.empty = inEmpty;
    assign in128.valid = inValid && (sel == 2'd2);
    assign in128.data  = inData;
    assign in128.sop   = inSop;
    assign in128.eop   = inEop;
    assign in128.empty = inEmpty;
    assign out256.ready = outReady;
    assign out384.ready = outReady;
    assign out128.ready = outReady;

    header_remover #(.DATA_WIDTH(DW), .HEADER_SIZE(256)) dut256 (
        .clk(clk), .rst_n(rst_n), .data_in(in256), .data_out(out256),
        .header_data(hdr256), .header_valid(hv256), .header_error(he256));
    header_remover #(.DATA_WIDTH(DW), .HEADER_SIZE(384)) dut384 (
        .clk(clk), .rst_n(rst_n), .data_in(in384), .data_out(out384),
        .header_data(hdr384), .header_valid(hv384), .header_error(he384));
    header_remover #(.DATA_WIDTH(DW), .HEADER_SIZE(128)) dut128 (
        .clk(clk), .rst_n(rst_n), .data_in(in128), .data_out(out128),
        .header_data(hdr128), .header_valid(hv128), .header_error(he128));

    logic          obsInReady, obsOutValid, obsOutSop, obsOutEop, obsHv, obsHe;
    logic [DW-1:0] obsOutData;
    logic [3:0]    obsOutEmpty;
    logic [383:0]  obsHdr;

    always_comb begin
        obsInReady  = in256.ready;
        obsOutValid = out256.valid;
        obsOutSop   = out256.sop;
        obsOutEop   = out256.eop;
        obsOutData  = out256.data;
        obsOutEmpty = out256.empty;
        obsHdr      = {128'b0, hdr256};
        obsHv       = hv256;
        obsHe       = he256;
        if (sel == 2'd1) begin
            obsInReady  = in384.ready;
            obsOutValid = out384.valid;
            obsOutSop   = out384.sop;
            obsOutEop   = out384.eop;
            obsOutData  = out384.data;
            obsOutEmpty = out384.empty;
            obsHdr      = hdr384;
            obsHv       = hv384;
            obsHe       = he384;
        end else if (sel == 2'd2) begin
            obsInReady  = in128.ready;
            obsOutValid = out128.valid;
            obsOutSop   = out128.sop;
            obsOutEop   = out128.eop;
            obsOutData  = out128.data;
            obsOutEmpty = out128.empty;
            obsHdr      = {256'b0, hdr128};
            obsHv       = hv128;
            obsHe       = he128;
        end
    end

    int   vectors = 0;
    int   miscompares = 0;
    vec_t tbl[$];

    task automatic checkOutput(input string name, input logic [383:0] act, input logic [383:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        inValid  = v.v;
        inSop    = v.sop;
        inEop    = v.eop;
        inData   = v.d;
        inEmpty  = v.e;
        outReady = v.rdy;
    endtask

    function automatic vec_t mk(logic v, logic sop, logic eop, logic [DW-1:0] d, logic [3:0] e, logic rdy,
                                logic xIr, logic xOv, logic xSop, logic xEop, logic [3:0] xE,
                                logic xHv, logic xHe);
        vec_t r;
        r.v = v; r.sop = sop; r.eop = eop; r.d = d; r.e = e; r.rdy = rdy;
        r.xInReady = xIr; r.xOutValid = xOv; r.xSop = xSop; r.xEop = xEop;
        r.xData = d; r.xEmpty = xE; r.xHv = xHv; r.xHe = xHe;
        return r;
    endfunction

    function automatic vec_t idleRow(logic xHv, logic xHe);
        return mk(1'b0, 1'b0, 1'b0, '0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, xHv, xHe);
    endfunction

    task automatic runTable(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkOutput($sformatf("%s[%0d].inReady", tag, i), obsInReady, tbl[i].xInReady);
            checkOutput($sformatf("%s[%0d].outValid", tag, i), obsOutValid, tbl[i].xOutValid);
            checkOutput($sformatf("%s[%0d].hdrValid", tag, i), obsHv, tbl[i].xHv);
            checkOutput($sformatf("%s[%0d].hdrError", tag, i), obsHe, tbl[i].xHe);
            if (tbl[i].xOutValid) begin
                checkOutput($sformatf("%s[%0d].data", tag, i), obsOutData, tbl[i].xData);
                checkOutput($sformatf("%s[%0d].sop", tag, i), obsOutSop, tbl[i].xSop);
                checkOutput($sformatf("%s[%0d].eop", tag, i), obsOutEop, tbl[i].xEop);
                checkOutput($sformatf("%s[%0d].empty", tag, i), obsOutEmpty, tbl[i].xEmpty);
            end
        end
        tbl.delete();
    endtask

    // Packet-level reference: short packets (or single-beat sop+eop) error out; otherwise the first
    // hwc words form the header and the remainder is the payload, framed afresh.
    task automatic runRandom(input logic [1:0] s, input int hwc, input int npk);
        beat_t      beats[$];
        beat_t      expPay[$];
        hev_t       expHdr[$];
        beat_t      b;
        hev_t       h;
        logic [DW-1:0] w[$];
        int         n, idx, cycles;
        logic       accOut;

        sel = s;
        for (int p = 0; p < npk; p++) begin
            if ($urandom_range(0, 3) == 0) begin
                b.d = {$urandom, $urandom, $urandom, $urandom};
                b.sop = 1'b0; b.eop = 1'($urandom_range(0, 1)); b.e = 4'($urandom);
                beats.push_back(b);
            end
            n = $urandom_range(1, hwc + 3);
            w.delete();
            for (int k = 0; k < n; k++) begin
                b.d   = {$urandom, $urandom, $urandom, $urandom};
                b.sop = (k == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
                b.eop = (k == n - 1);
                b.e   = 4'($urandom);
                beats.push_back(b);
                w.push_back(b.d);
                if (k >= hwc) begin
                    beat_t o;
                    o.d = b.d; o.sop = (k == hwc); o.eop = b.eop; o.e = b.eop ? b.e : 4'd0;
                    expPay.push_back(o);
                end
            end
            h.isErr = (n == 1) || (n < hwc);
            h.hdr   = '0;
            if (!h.isErr)
                for (int j = 0; j < hwc; j++) h.hdr = (h.hdr << DW) | {256'b0, w[j]};
            expHdr.push_back(h);
        end

        idx = 0;
        cycles = 0;
        while ((idx < beats.size() || expPay.size() > 0 || expHdr.size() > 0) && cycles < 5000) begin
            @(posedge clk);
            #1;
            inValid = (idx < beats.size()) && ($urandom_range(0, 3) != 0);
            if (idx < beats.size()) begin
                inData = beats[idx].d; inSop = beats[idx].sop; inEop = beats[idx].eop; inEmpty = beats[idx].e;
            end
            outReady = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (obsHv || obsHe) begin
                if (obsHv && obsHe) checkOutput("rnd.bothPulses", 1, 0);
                if (expHdr.size() == 0) begin
                    checkOutput("rnd.unexpectedHdrEvent", 1, 0);
                end else begin
                    h = expHdr.pop_front();
                    checkOutput("rnd.hdrKindErr", obsHe, h.isErr);
                    if (!h.isErr) checkOutput("rnd.headerData", obsHdr, h.hdr);
                end
            end
            accOut = obsOutValid && outReady;
            if (accOut) begin
                if (expPay.size() == 0) begin
                    checkOutput("rnd.unexpectedOut", 1, 0);
                end else begin
                    b = expPay.pop_front();
                    checkOutput("rnd.data", obsOutData, b.d);
                    checkOutput("rnd.sop", obsOutSop, b.sop);
                    checkOutput("rnd.eop", obsOutEop, b.eop);
                    checkOutput("rnd.empty", obsOutEmpty, b.e);
                end
            end
            if (inValid && obsInReady) idx++;
            cycles++;
        end
        checkOutput("rnd.beatsConsumed", 384'(idx), 384'(beats.size()));
        checkOutput("rnd.payloadLeft", 384'(expPay.size()), 0);
        checkOutput("rnd.hdrEventsLeft", 384'(expHdr.size()), 0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    localparam logic [DW-1:0] HA = {4{32'hA0A0_0001}};
    localparam logic [DW-1:0] HB = {4{32'hB0B0_0002}};
    localparam logic [DW-1:0] HC = {4{32'hC0C0_0003}};
    localparam logic [DW-1:0] P0 = {4{32'h1111_0010}};
    localparam logic [DW-1:0] P1 = {4{32'h2222_0020}};
    localparam logic [DW-1:0] P2 = {4{32'h3333_0030}};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        sel = 2'd0;
        inValid = 1'b0; inSop = 1'b0; inEop = 1'b0; inData = '0; inEmpty = '0; outReady = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            checkOutput($sformatf("reset%0d.inReady", s), obsInReady, 1);
            checkOutput($sformatf("reset%0d.outValid", s), obsOutValid, 0);
            checkOutput($sformatf("reset%0d.header", s), obsHdr, 0);
            checkOutput($sformatf("reset%0d.hv", s), obsHv, 0);
            checkOutput($sformatf("reset%0d.he", s), obsHe, 0);
        end
        sel = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // Basic strip, downstream always ready; empty on non-eop beats must be masked.
        tbl.push_back(mk(1, 1, 0, HA, 4'd0, 1, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 0, HB, 4'd0, 1, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 0, P0, 4'd3, 1, 1, 1, 1, 0, 4'd0, 1, 0));
        tbl.push_back(mk(1, 0, 0, P1, 4'd0, 1, 1, 1, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 1, P2, 4'd5, 1, 1, 1, 0, 1, 4'd5, 0, 0));
        tbl.push_back(idleRow(0, 0));
        runTable("basic");
        checkOutput("basic.header", obsHdr, {128'b0, HA, HB});

        // Backpressure: header absorbed with ready low; payload stalls mirror downstream ready.
        tbl.push_back(mk(1, 1, 0, HA, 4'd0, 0, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 0, HB, 4'd0, 0, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 0, P0, 4'd0, 1, 1, 1, 1, 0, 4'd0, 1, 0));
        tbl.push_back(mk(1, 0, 0, P1, 4'd0, 0, 0, 1, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 0, P1, 4'd0, 1, 1, 1, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 1, P2, 4'd5, 0, 0, 1, 0, 1, 4'd5, 0, 0));
        tbl.push_back(mk(1, 0, 1, P2, 4'd5, 1, 1, 1, 0, 1, 4'd5, 0, 0));
        tbl.push_back(idleRow(0, 0));
        runTable("bp");
        checkOutput("bp.header", obsHdr, {128'b0, HA, HB});

        // Zero-payload packet on the 256-bit header instance.
        tbl.push_back(mk(1, 1, 0, HB, 4'd0, 1, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 1, HA, 4'd0, 1, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(idleRow(1, 0));
        tbl.push_back(idleRow(0, 0));
        runTable("zeroPay");
        checkOutput("zeroPay.header", obsHdr, {128'b0, HB, HA});

        // Short packet on the 384-bit instance, then a good one.
        sel = 2'd1;
        tbl.push_back(mk(1, 1, 0, HA, 4'd0, 1, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 1, HB, 4'd0, 1, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(idleRow(0, 1));
        tbl.push_back(idleRow(0, 0));
        tbl.push_back(mk(1, 1, 0, HC, 4'd0, 1, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 0, HB, 4'd0, 1, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 0, HA, 4'd0, 1, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 1, P0, 4'd2, 1, 1, 1, 1, 1, 4'd2, 1, 0));
        tbl.push_back(idleRow(0, 0));
        runTable("short384");
        checkOutput("short384.header", obsHdr, {HC, HB, HA});

        // Single-word header: payload beat carries sop and eop together.
        sel = 2'd2;
        tbl.push_back(mk(1, 1, 0, HC, 4'd0, 1, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 1, P1, 4'd7, 1, 1, 1, 1, 1, 4'd7, 1, 0));
        tbl.push_back(idleRow(0, 0));
        runTable("hwc1");
        checkOutput("hwc1.header", obsHdr, {256'b0, HC});

        // Reset in the middle of the payload; the orphaned tail must be dropped.
        sel = 2'd0;
        tbl.push_back(mk(1, 1, 0, HA, 4'd0, 1, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 0, HB, 4'd0, 1, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 0, P0, 4'd0, 1, 1, 1, 1, 0, 4'd0, 1, 0));
        runTable("preRst");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        inValid = 1'b1; inSop = 1'b0; inEop = 1'b0; inData = P1; outReady = 1'b1;
        #1;
        checkOutput("midRst.outValid", obsOutValid, 0);
        checkOutput("midRst.inReady", obsInReady, 1);
        checkOutput("midRst.header", obsHdr, 0);
        checkOutput("midRst.hv", obsHv, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tbl.push_back(mk(1, 0, 1, P2, 4'd5, 1, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 1, 0, HC, 4'd0, 1, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 0, HB, 4'd0, 1, 1, 0, 0, 0, 4'd0, 0, 0));
        tbl.push_back(mk(1, 0, 1, P0, 4'd1, 1, 1, 1, 1, 1, 4'd1, 1, 0));
        tbl.push_back(idleRow(0, 0));
        runTable("postRst");
        checkOutput("postRst.header", obsHdr, {128'b0, HC, HB});

        runRandom(2'd0, 2, 40);
        runRandom(2'd1, 3, 40);
        runRandom(2'd2, 1, 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
